sram_seq_ctrl: RTL and testbench
================================

Name: sram_seq_ctrl

Overview:
- Command sequencer in front of the 4-block compute SRAM macro (6-bit address, 16-bit word, 64-bit input vector, 72-bit sum).
- Accepts one host command at a time (write word, read word, compute) over a valid/ready channel.
- Drives the macro's addr/data/in/wen/ren/comp_en with single-cycle registered pulses, then waits a fixed latency.
- Returns the read word or the accumulated sum on a valid/ready response channel.

Parameters:
- ADDR_W, 6, SRAM word address width
- DATA_W, 16, SRAM data word width
- IN_W, 64, compute input vector width
- SUM_W, 72, compute sum width (4 x 18 bits)
- RD_LAT, 1, cycles from the ren pulse to a valid sram_out (1..15)
- CMP_LAT, 2, cycles from the comp_en pulse to a valid sram_sum (1..15)

Ports:
- clk  in  1  single clock; all state on its rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_op  in  2  00 write, 01 read, 10 compute, 11 illegal
- cmd_addr  in  ADDR_W  word address
- cmd_data  in  DATA_W  write data
- cmd_in  in  IN_W  compute input vector
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_data  out  SUM_W  read word zero-extended, or compute sum
- rsp_err  out  1  response belongs to an illegal op
- sram_addr  out  ADDR_W  to macro addr
- sram_data  out  DATA_W  to macro data
- sram_in  out  IN_W  to macro in
- sram_wen  out  1  to macro wen
- sram_ren  out  1  to macro ren
- sram_comp_en  out  1  to macro comp_en
- sram_out  in  DATA_W  macro read data
- sram_sum  in  SUM_W  macro sum

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, latency counter 0. Reset asserted mid-operation aborts the operation; any pending response is discarded.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- cmd_ready is 1 only in IDLE; it is registered-state combinational.
- IDLE: on cmd_valid, latch op/addr/data/in into sram_addr/sram_data/sram_in (held until the next accept), then go to ISSUE.
- ISSUE (exactly 1 cycle): assert only the strobe for the op.
  - write: sram_wen=1, next state IDLE, no response.
  - read: sram_ren=1, counter=RD_LAT, next state WAIT.
  - compute: sram_comp_en=1, counter=CMP_LAT, next state WAIT.
  - illegal: no strobe, rsp_data=0, rsp_err=1, next state RESP.
- WAIT: decrement the counter each cycle. When the counter reaches 1, capture the result and go to RESP:
  - read: rsp_data = {zeros, sram_out}.
  - compute: rsp_data = sram_sum.
  - Both set rsp_err=0.
- RESP: rsp_valid=1; rsp_data and rsp_err stay stable until rsp_ready. On handshake: rsp_valid=0, then IDLE. A new command is accepted no earlier than the cycle after the response handshake.
- Latency, command accepted at edge T:
  - strobe high during cycle T+1;
  - read rsp_valid first high in cycle T+2+RD_LAT;
  - compute rsp_valid first high in cycle T+2+CMP_LAT;
  - write: cmd_ready high again in cycle T+2.
- At most one strobe is high in any cycle. Strobes never repeat while waiting or under rsp_ready backpressure.
- Address covers the full 0..63 range with no range check. Addresses 0 and 63 behave identically to the others.

Optional Feature:
- Macro SRAM_SEQ_CTRL_STATS_EN.
- When defined: adds outputs stat_wr, stat_rd, stat_cmp, stat_err (each 16 bits).
  - Each counter increments on ISSUE of its op type.
  - Counters saturate at 0xFFFF and reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset with cmd_valid=1 -> all outputs 0 and cmd_ready=0 during reset; cmd_ready=1 the cycle after release.
- Write then read: write addr 0x2A, data 0xBEEF -> sram_wen pulses 1 cycle with sram_addr=0x2A and sram_data=0xBEEF. Read 0x2A with model sram_out=0xBEEF -> rsp_data=0x000...BEEF, rsp_err=0, rsp_valid in cycle T+3 (RD_LAT=1).
- Compute: cmd_in=0xFFFF_0000_FFFF_0000, model sram_sum=72'h12_3456_789A -> sram_comp_en pulses once, rsp_data=72'h12_3456_789A at T+4 (CMP_LAT=2).
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid and rsp_data stable, cmd_ready=0, no additional strobes.
- Illegal op 11 -> no strobe; rsp_err=1, rsp_data=0 at T+2.
- Mid-op reset: assert reset during WAIT of a compute -> rsp_valid never asserts; a fresh read after release completes normally. With SRAM_SEQ_CTRL_STATS_EN defined: 3 writes, 2 reads, 1 compute, 1 illegal -> counters read 3/2/1/1.

Source files
------------

// File: rtl/sram_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sram_seq_ctrl
//
// Command sequencer that sits in front of the 4-block compute SRAM macro.
// The host hands over one command at a time (write word, read word, compute).
// The controller drives the macro with a single-cycle registered strobe,
// waits a fixed latency, then returns the read word or the compute sum on a
// valid/ready response channel.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_op                   00 write, 01 read, 10 compute, 11 illegal
//   cmd_addr/data/in         command payload
//   rsp_valid / rsp_ready    response handshake
//   rsp_data / rsp_err       zero-extended read word or compute sum; error flag
//   sram_addr/data/in        macro address/data/input vector (held)
//   sram_wen/ren/comp_en     macro strobes (one-cycle pulses)
//   sram_out / sram_sum      macro read data / compute sum
//
// Optional build macro SRAM_SEQ_CTRL_STATS_EN adds the saturating 16-bit
// issue counters stat_wr, stat_rd, stat_cmp and stat_err.
// ---------------------------------------------------------------------------
module sram_seq_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int IN_W    = 64,
    parameter int SUM_W   = 72,
    parameter int RD_LAT  = 1,
    parameter int CMP_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [IN_W-1:0]   cmd_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [SUM_W-1:0]  rsp_data,
    output logic              rsp_err,
`ifdef SRAM_SEQ_CTRL_STATS_EN
    output logic [15:0]       stat_wr,
    output logic [15:0]       stat_rd,
    output logic [15:0]       stat_cmp,
    output logic [15:0]       stat_err,
`endif
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data,
    output logic [IN_W-1:0]   sram_in,
    output logic              sram_wen,
    output logic              sram_ren,
    output logic              sram_comp_en,
    input  logic [DATA_W-1:0] sram_out,
    input  logic [SUM_W-1:0]  sram_sum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_WR  = 2'b00,
        OP_RD  = 2'b01,
        OP_CMP = 2'b10,
        OP_ILL = 2'b11
    } op_t;

    localparam logic [3:0] RD_CNT  = 4'(RD_LAT);
    localparam logic [3:0] CMP_CNT = 4'(CMP_LAT);

    state_t     state;
    op_t        op_q;
    logic [3:0] cnt;

    // Commands are only taken while idle. Gating with reset keeps the
    // handshake closed for as long as reset is held.
    assign cmd_ready = (state == IDLE) && !reset;

    // Main sequencer. Strobes are set on the accepting edge so they are high
    // exactly for the single ISSUE cycle and are cleared on every other edge,
    // which guarantees no repeats during WAIT or response backpressure.
    // The WAIT counter is loaded with the latency and the result is captured
    // on the edge where it reads 1, i.e. exactly LAT cycles after the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= OP_WR;
            cnt          <= 4'd0;
            sram_addr    <= '0;
            sram_data    <= '0;
            sram_in      <= '0;
            sram_wen     <= 1'b0;
            sram_ren     <= 1'b0;
            sram_comp_en <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            sram_wen     <= 1'b0;
            sram_ren     <= 1'b0;
            sram_comp_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q         <= op_t'(cmd_op);
                        sram_addr    <= cmd_addr;
                        sram_data    <= cmd_data;
                        sram_in      <= cmd_in;
                        sram_wen     <= (cmd_op == OP_WR);
                        sram_ren     <= (cmd_op == OP_RD);
                        sram_comp_en <= (cmd_op == OP_CMP);
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    case (op_q)
                        OP_WR: begin
                            state <= IDLE;
                        end
                        OP_RD: begin
                            cnt   <= RD_CNT;
                            state <= WAIT;
                        end
                        OP_CMP: begin
                            cnt   <= CMP_CNT;
                            state <= WAIT;
                        end
                        default: begin
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    endcase
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        if (op_q == OP_CMP) begin
                            rsp_data <= sram_sum;
                        end else begin
                            rsp_data <= {{(SUM_W-DATA_W){1'b0}}, sram_out};
                        end
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        cnt       <= 4'd0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_SEQ_CTRL_STATS_EN
    // Per-op issue counters. Each op spends exactly one cycle in ISSUE, so
    // counting there counts each accepted command once. Counters stick at
    // all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_wr  <= 16'd0;
            stat_rd  <= 16'd0;
            stat_cmp <= 16'd0;
            stat_err <= 16'd0;
        end else if (state == ISSUE) begin
            case (op_q)
                OP_WR:   if (stat_wr  != 16'hFFFF) stat_wr  <= stat_wr  + 16'd1;
                OP_RD:   if (stat_rd  != 16'hFFFF) stat_rd  <= stat_rd  + 16'd1;
                OP_CMP:  if (stat_cmp != 16'hFFFF) stat_cmp <= stat_cmp + 16'd1;
                default: if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_seq_ctrl
//
// Bench for sram_seq_ctrl. A behavioural model of the SRAM macro answers the
// strobes (read data and sum are only correct in the cycle the latency says,
// and inverted otherwise). A host-level reference keeps its own copy of the
// memory contents and the op counts, and predicts every response.
// ---------------------------------------------------------------------------
module tb_sram_seq_ctrl;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 16;
    localparam int IN_W    = 64;
    localparam int SUM_W   = 72;
    localparam int RD_LAT  = 1;
    localparam int CMP_LAT = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic [IN_W-1:0]   cmd_in = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [SUM_W-1:0]  rsp_data;
    logic              rsp_err;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data;
    logic [IN_W-1:0]   sram_in;
    logic              sram_wen;
    logic              sram_ren;
    logic              sram_comp_en;
    logic [DATA_W-1:0] sram_out;
    logic [SUM_W-1:0]  sram_sum;
`ifdef SRAM_SEQ_CTRL_STATS_EN
    logic [15:0]       stat_wr;
    logic [15:0]       stat_rd;
    logic [15:0]       stat_cmp;
    logic [15:0]       stat_err;
`endif

    sram_seq_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IN_W   (IN_W),
        .SUM_W  (SUM_W),
        .RD_LAT (RD_LAT),
        .CMP_LAT(CMP_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_in      (cmd_in),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
`ifdef SRAM_SEQ_CTRL_STATS_EN
        .stat_wr     (stat_wr),
        .stat_rd     (stat_rd),
        .stat_cmp    (stat_cmp),
        .stat_err    (stat_err),
`endif
        .sram_addr   (sram_addr),
        .sram_data   (sram_data),
        .sram_in     (sram_in),
        .sram_wen    (sram_wen),
        .sram_ren    (sram_ren),
        .sram_comp_en(sram_comp_en),
        .sram_out    (sram_out),
        .sram_sum    (sram_sum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    int n_rd   = 0;
    int n_cmp  = 0;
    int n_err  = 0;

    // Initial content of a never-written word, shared by macro and reference.
    function automatic logic [15:0] pattern(input logic [5:0] a);
        return {a, 2'b10, ~a, 2'b01};
    endfunction

    // Behavioural SRAM macro: stores on wen, presents the read word exactly
    // RD_LAT cycles after ren and the sum exactly CMP_LAT cycles after
    // comp_en. Outside those cycles it shows the inverted value.
    logic [15:0] mem [64];
    logic [63:0] written = '0;
    logic [4:0]  rd_age  = 5'd0;
    logic [4:0]  cmp_age = 5'd0;
    logic [15:0] rd_word = 16'h0000;
    logic [71:0] cmp_val = '0;
    logic [71:0] macro_sum = '0;

    always @(posedge clk) begin
        if (sram_wen) begin
            mem[sram_addr]     <= sram_data;
            written[sram_addr] <= 1'b1;
        end
        if (sram_ren) begin
            rd_age  <= 5'd1;
            rd_word <= written[sram_addr] ? mem[sram_addr] : pattern(sram_addr);
        end else if (rd_age != 5'd0 && rd_age != 5'd31) begin
            rd_age <= rd_age + 5'd1;
        end
        if (sram_comp_en) begin
            cmp_age <= 5'd1;
            cmp_val <= macro_sum;
        end else if (cmp_age != 5'd0 && cmp_age != 5'd31) begin
            cmp_age <= cmp_age + 5'd1;
        end
    end

    assign sram_out = (rd_age == 5'(RD_LAT)) ? rd_word : ~rd_word;
    assign sram_sum = (cmp_age == 5'(CMP_LAT)) ? cmp_val : ~cmp_val;

    // Running total of strobe-cycles; a cycle with two strobes adds two.
    int strobe_total = 0;
    always @(posedge clk) begin
        strobe_total <= strobe_total + {31'b0, sram_wen} + {31'b0, sram_ren}
                        + {31'b0, sram_comp_en};
    end

    // Host-level view of the memory.
    logic [15:0] ref_mem [64];

    task automatic checkOutput(input string tag, input logic [71:0] obs,
                               input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and checks strobe, latency, response and
    // backpressure behaviour against the reference.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] addr,
                                 input logic [15:0] data, input logic [63:0] vin,
                                 input logic [71:0] sum, input int hold);
        int          waited;
        int          strobes_before;
        int          lat;
        logic [71:0] exp_data;
        logic        exp_err;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            nextCycle();
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            checkOutput("cmd_ready_timeout", {71'b0, cmd_ready}, 72'd1);
            return;
        end
        macro_sum      = sum;
        strobes_before = strobe_total;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_in    = vin;
        nextCycle();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 6'($urandom);
        cmd_data  = 16'($urandom);
        cmd_in    = {$urandom, $urandom};
        checkOutput("issue_wen", {71'b0, sram_wen}, {71'b0, op == 2'b00});
        checkOutput("issue_ren", {71'b0, sram_ren}, {71'b0, op == 2'b01});
        checkOutput("issue_comp_en", {71'b0, sram_comp_en}, {71'b0, op == 2'b10});
        checkOutput("issue_addr", {66'b0, sram_addr}, {66'b0, addr});
        checkOutput("issue_data", {56'b0, sram_data}, {56'b0, data});
        checkOutput("issue_in", {8'b0, sram_in}, {8'b0, vin});
        checkOutput("issue_cmd_ready", {71'b0, cmd_ready}, 72'd0);
        if (op == 2'b00) begin
            ref_mem[addr] = data;
            n_wr++;
            nextCycle();
            checkOutput("wr_ready_back", {71'b0, cmd_ready}, 72'd1);
            checkOutput("wr_no_rsp", {71'b0, rsp_valid}, 72'd0);
        end else begin
            case (op)
                2'b01: begin
                    lat      = RD_LAT + 2;
                    exp_data = {56'b0, ref_mem[addr]};
                    exp_err  = 1'b0;
                    n_rd++;
                end
                2'b10: begin
                    lat      = CMP_LAT + 2;
                    exp_data = sum;
                    exp_err  = 1'b0;
                    n_cmp++;
                end
                default: begin
                    lat      = 2;
                    exp_data = '0;
                    exp_err  = 1'b1;
                    n_err++;
                end
            endcase
            for (int c = 2; c < lat; c++) begin
                nextCycle();
                checkOutput("rsp_early", {71'b0, rsp_valid}, 72'd0);
            end
            nextCycle();
            checkOutput("rsp_valid", {71'b0, rsp_valid}, 72'd1);
            checkOutput("rsp_data", rsp_data, exp_data);
            checkOutput("rsp_err", {71'b0, rsp_err}, {71'b0, exp_err});
            checkOutput("rsp_cmd_ready", {71'b0, cmd_ready}, 72'd0);
            for (int h = 0; h < hold; h++) begin
                nextCycle();
                checkOutput("hold_valid", {71'b0, rsp_valid}, 72'd1);
                checkOutput("hold_data", rsp_data, exp_data);
                checkOutput("hold_err", {71'b0, rsp_err}, {71'b0, exp_err});
                checkOutput("hold_cmd_ready", {71'b0, cmd_ready}, 72'd0);
            end
            rsp_ready = 1'b1;
            nextCycle();
            rsp_ready = 1'b0;
            checkOutput("rsp_cleared", {71'b0, rsp_valid}, 72'd0);
            checkOutput("ready_after_rsp", {71'b0, cmd_ready}, 72'd1);
        end
        checkOutput("strobe_count", 72'(strobe_total - strobes_before),
                    (op == 2'b11) ? 72'd0 : 72'd1);
    endtask

    logic [1:0]  r_op;
    logic [5:0]  r_addr;
    logic [15:0] r_data;
    logic [63:0] r_in;
    logic [71:0] r_sum;
    int          r_hold;

    // Directed steps first, then a randomized command stream.
    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = pattern(6'(i));
        end

        // Reset held with a pending command.
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 6'h15;
        cmd_data  = 16'h1234;
        cmd_in    = 64'hDEAD_BEEF_0BAD_F00D;
        rsp_ready = 1'b1;
        repeat (3) nextCycle();
        checkOutput("rst_cmd_ready", {71'b0, cmd_ready}, 72'd0);
        checkOutput("rst_rsp_valid", {71'b0, rsp_valid}, 72'd0);
        checkOutput("rst_rsp_data", rsp_data, 72'd0);
        checkOutput("rst_rsp_err", {71'b0, rsp_err}, 72'd0);
        checkOutput("rst_sram_addr", {66'b0, sram_addr}, 72'd0);
        checkOutput("rst_sram_data", {56'b0, sram_data}, 72'd0);
        checkOutput("rst_sram_in", {8'b0, sram_in}, 72'd0);
        checkOutput("rst_strobes", {69'b0, sram_wen, sram_ren, sram_comp_en}, 72'd0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        reset     = 1'b0;
        #1;
        checkOutput("ready_after_release", {71'b0, cmd_ready}, 72'd1);

        // Write then read back, compute under backpressure, illegal op.
        applyStimulus(2'b00, 6'h2A, 16'hBEEF, 64'h0, 72'h0, 0);
        applyStimulus(2'b01, 6'h2A, 16'h0000, 64'h0, 72'h0, 0);
        applyStimulus(2'b10, 6'h11, 16'h0000, 64'hFFFF_0000_FFFF_0000,
                      72'h12_3456_789A, 5);
        applyStimulus(2'b11, 6'h07, 16'h5555, 64'h0, 72'h0, 2);

        // Address extremes.
        applyStimulus(2'b00, 6'h00, 16'hA5A5, 64'h0, 72'h0, 0);
        applyStimulus(2'b00, 6'h3F, 16'h5A5A, 64'h0, 72'h0, 0);
        applyStimulus(2'b01, 6'h00, 16'h0000, 64'h0, 72'h0, 1);
        applyStimulus(2'b01, 6'h3F, 16'h0000, 64'h0, 72'h0, 0);

        // Reset during the WAIT phase of a compute.
        while (cmd_ready !== 1'b1) nextCycle();
        macro_sum = 72'hAB_CDEF_0123_4567_89AB;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_addr  = 6'h05;
        cmd_in    = 64'h0123_4567_89AB_CDEF;
        nextCycle();
        cmd_valid = 1'b0;
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("abort_rsp_valid", {71'b0, rsp_valid}, 72'd0);
        checkOutput("abort_cmd_ready", {71'b0, cmd_ready}, 72'd0);
        checkOutput("abort_sram_in", {8'b0, sram_in}, 72'd0);
        nextCycle();
        reset = 1'b0;
        n_wr  = 0;
        n_rd  = 0;
        n_cmp = 0;
        n_err = 0;
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            checkOutput("abort_no_rsp", {71'b0, rsp_valid}, 72'd0);
        end
        applyStimulus(2'b01, 6'h2A, 16'h0000, 64'h0, 72'h0, 0);

        // Randomized stream, biased toward a few addresses so reads hit writes.
        for (int i = 0; i < 40; i++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_addr = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7))
                                                  : 6'($urandom_range(0, 63));
            r_data = 16'($urandom);
            r_in   = {$urandom, $urandom};
            r_sum  = {8'($urandom), $urandom, $urandom};
            r_hold = int'($urandom_range(0, 3));
            applyStimulus(r_op, r_addr, r_data, r_in, r_sum, r_hold);
        end

`ifdef SRAM_SEQ_CTRL_STATS_EN
        checkOutput("stat_wr", {56'b0, stat_wr}, 72'(n_wr));
        checkOutput("stat_rd", {56'b0, stat_rd}, 72'(n_rd));
        checkOutput("stat_cmp", {56'b0, stat_cmp}, 72'(n_cmp));
        checkOutput("stat_err", {56'b0, stat_err}, 72'(n_err));
`endif
        $display("[TB] ops since last reset: wr=%0d rd=%0d cmp=%0d err=%0d",
                 n_wr, n_rd, n_cmp, n_err);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so a stuck handshake cannot hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no completion expected finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
